// File: rtl/cla4_clkd.sv
// rtl/cla4_clkd.sv - registered-input 4-bit carry-lookahead adder
// Optional output register stage enabled by defining CLA4_OUTPUT_REG_EN.
module cla4_clkd (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] r_a_q;
    logic [3:0] r_b_q;
    logic       r_c_q;

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;
    logic [3:0] w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_q <= 4'd0;
            r_b_q <= 4'd0;
            r_c_q <= 1'b0;
        end else begin
            r_a_q <= a_in;
            r_b_q <= b_in;
            r_c_q <= c_in;
        end
    end

    assign w_g = r_a_q & r_b_q;
    assign w_p = r_a_q ^ r_b_q;

    // Every carry is a flat sum-of-products of g, p and c0 so no carry depends on another.
    assign w_c[0] = r_c_q;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & r_c_q);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & r_c_q);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_c_q);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c_q);

    assign w_sum = w_p ^ w_c[3:0];

`ifdef CLA4_OUTPUT_REG_EN
    logic [3:0] r_s;
    logic       r_c_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s     <= 4'd0;
            r_c_out <= 1'b0;
        end else begin
            r_s     <= w_sum;
            r_c_out <= w_c[4];
        end
    end

    assign s     = r_s;
    assign c_out = r_c_out;
`else
    assign s     = w_sum;
    assign c_out = w_c[4];
`endif

endmodule

// File: tb/tb_cla4_clkd.sv
// tb/tb_cla4_clkd.sv - directed and exhaustive checks for cla4_clkd
module tb_cla4_clkd;

`ifdef CLA4_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] a_in = 4'd0;
    logic [3:0] b_in = 4'd0;
    logic       c_in = 1'b0;
    logic [3:0] s;
    logic       c_out;

    int checks = 0;
    int errors = 0;

    // Expected result one and two edges after capture.
    logic [4:0] m_q1 = 5'd0;
    logic [4:0] m_q2 = 5'd0;
    logic [4:0] m_exp;

    always #5 clk = ~clk;

    cla4_clkd dut (
        .clk   (clk),
        .reset (reset),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .s     (s),
        .c_out (c_out)
    );

    task automatic check(input string tag, input logic [4:0] exp);
        checks++;
        assert ({c_out, s} === exp)
        else begin
            errors++;
            $error("FAIL %s: observed c_out,s=%b expected %b", tag, {c_out, s}, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [4:0] sum, input string tag);
        reset = rst;
        a_in  = a;
        b_in  = b;
        c_in  = c;
        @(posedge clk);
        m_q2 = rst ? 5'd0 : m_q1;
        m_q1 = rst ? 5'd0 : sum;
        m_exp = (LAT == 1) ? m_q1 : m_q2;
        #1;
        check(tag, m_exp);
    endtask

    task automatic hold_check(input string tag);
        a_in = ~a_in;
        b_in = ~b_in;
        c_in = ~c_in;
        #3;
        check(tag, m_exp);
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [4:0] e;

        step(1'b1, 4'hF, 4'hF, 1'b1, 5'h00, "reset_edge1");
        step(1'b1, 4'hF, 4'hF, 1'b1, 5'h00, "reset_edge2");

        step(1'b0, 4'b1010, 4'b0101, 1'b0, 5'b0_1111, "a_plus_5");
        hold_check("hold_a_plus_5");
        step(1'b0, 4'b1111, 4'b0001, 1'b1, 5'b1_0001, "wrap_f_1_1");
        hold_check("hold_wrap");
        step(1'b0, 4'b1111, 4'b1111, 1'b1, 5'b1_1111, "max_f_f_1");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 5'b0_0000, "zero");

        step(1'b0, 4'b0000, 4'b1111, 1'b0, 5'b0_1111, "b2b_0_f");
        step(1'b0, 4'b1001, 4'b1001, 1'b1, 5'b1_0011, "b2b_9_9_1");
        step(1'b1, 4'b0110, 4'b0111, 1'b1, 5'h00, "midstream_reset");
        step(1'b0, 4'b0111, 4'b1000, 1'b1, 5'b1_0000, "resume_7_8_1");
        step(1'b0, 4'b0011, 4'b0101, 1'b0, 5'b0_1000, "add_3_5");

        for (int i = 0; i < 512; i++) begin
            a = i[8:5];
            b = i[4:1];
            c = i[0];
            e = {1'b0, a} + {1'b0, b} + {4'd0, c};
            step(1'b0, a, b, c, e, $sformatf("sweep_%0d", i));
        end
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, "flush1");
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, "flush2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
